spi_xfer_seq: RTL and testbench

Transaction sequencer for the byte-wide SPI master engine in the avionics sensor path. Accepts one register-access request (address, direction, 1..MAX_BYTES payload) and drives chip select. Issues a command byte followed by payload bytes through the engine's start/data_in/new_data handshake, and collects read bytes. Returns a single done pulse with read data and an error flag. Sits between the sensor-polling logic and spi_master.

---
 rtl/spi_xfer_seq_pkg.sv | 37 +++
 rtl/spi_xfer_seq_cycle_cnt.sv | 28 ++
 rtl/spi_xfer_seq.sv | 176 +++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_seq_pkg.sv
// Shared types and helpers for the SPI register-access sequencer.
package spi_xfer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP,
    ST_HOLD,
    ST_FIN
  } state_e;

  localparam int         CMD_RD_BIT    = 7;
  localparam logic [7:0] DUMMY_RD_BYTE = 8'h00;

  function automatic logic [7:0] cmd_byte(input logic rd, input logic [6:0] addr);
    logic [7:0] b;
    b             = '0;
    b[6:0]        = addr;
    b[CMD_RD_BIT] = rd;
    return b;
  endfunction

  // Requested length 0 means one byte; anything above the payload buffer is clamped.
  function automatic int eff_len(input int len, input int max_b);
    if (len == 0) return 1;
    if (len > max_b) return max_b;
    return len;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_xfer_seq_cycle_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
module spi_xfer_seq_cycle_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// Register-access transaction sequencer in front of a byte-wide SPI master:
// command byte + payload bytes under one chip select, one done pulse at the end.
module spi_xfer_seq
  import spi_xfer_seq_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   req_rd_i,
  input  logic [6:0]             req_addr_i,
  input  logic [2:0]             req_len_i,
  input  logic [8*MAX_BYTES-1:0] wr_data_i,
  output logic [8*MAX_BYTES-1:0] rd_data_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   cs_n_o,
  output logic                   spi_start_o,
  output logic [7:0]             spi_data_in_o,
  input  logic [7:0]             spi_data_out_i,
  input  logic                   spi_new_data_i,
  input  logic                   spi_busy_i
);

  localparam int IW      = $clog2(MAX_BYTES + 1);
  localparam int CNT_MAX = max3(CS_SETUP, CS_HOLD, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e                      state_q;
  logic                        rd_q;
  logic [6:0]                  addr_q;
  logic [IW-1:0]               len_q, idx_q;
  logic [MAX_BYTES-1:0][7:0]   wr_q, rd_data_q;
  logic                        cs_n_q, start_q, done_q, err_q, busy_q;
  logic [7:0]                  data_in_q;

  logic                        cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]               cnt_val;
  logic [7:0]                  wr_byte;

  // Setup, hold and per-byte timeout never overlap, so one counter serves all three.
  spi_xfer_seq_cycle_cnt #(.W(CW)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_IDLE: if (req_i) begin
        cnt_load = 1'b1;
        cnt_val  = CW'(CS_SETUP - 1);
      end
      ST_SETUP: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CW'(TIMEOUT - 1);
      end else begin
        cnt_dec = 1'b1;
      end
      ST_XFER: if (!spi_new_data_i) begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(CS_HOLD - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP: if (!spi_busy_i) begin
        cnt_load = 1'b1;
        cnt_val  = (idx_q == len_q) ? CW'(CS_HOLD - 1) : CW'(TIMEOUT - 1);
      end
      ST_HOLD: cnt_dec = !cnt_zero;
      default: ;
    endcase
  end

  // Payload byte for the next wire byte: wire byte idx+1 carries payload byte idx.
  always_comb begin
    wr_byte = '0;
    for (int b = 0; b < MAX_BYTES; b++)
      if (idx_q == IW'(b)) wr_byte = wr_q[b];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_q      <= '0;
      rd_data_q <= '0;
      cs_n_q    <= 1'b1;
      start_q   <= 1'b0;
      data_in_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (req_i) begin
          rd_q      <= req_rd_i;
          addr_q    <= req_addr_i;
          len_q     <= IW'(eff_len(int'(req_len_i), MAX_BYTES));
          wr_q      <= wr_data_i;
          rd_data_q <= '0;
          err_q     <= 1'b0;
          cs_n_q    <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= ST_SETUP;
        end
        ST_SETUP: if (cnt_zero) begin
          idx_q     <= '0;
          start_q   <= 1'b1;
          data_in_q <= cmd_byte(rd_q, addr_q);
          state_q   <= ST_XFER;
        end
        ST_XFER: begin
          if (spi_new_data_i) begin
            // Response to the command byte (idx 0) is discarded.
            if (rd_q)
              for (int b = 0; b < MAX_BYTES; b++)
                if (idx_q == IW'(b + 1)) rd_data_q[b] <= spi_data_out_i;
            start_q <= 1'b0;
            state_q <= ST_GAP;
          end else if (cnt_zero) begin
            err_q   <= 1'b1;
            start_q <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_GAP: if (!spi_busy_i) begin
          if (idx_q == len_q) begin
            state_q <= ST_HOLD;
          end else begin
            idx_q     <= idx_q + 1'b1;
            start_q   <= 1'b1;
            data_in_q <= rd_q ? DUMMY_RD_BYTE : wr_byte;
            state_q   <= ST_XFER;
          end
        end
        ST_HOLD: if (cnt_zero) begin
          cs_n_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data_o     = rd_data_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign cs_n_o        = cs_n_q;
  assign spi_start_o   = start_q;
  assign spi_data_in_o = data_in_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed + random bench for spi_xfer_seq with a behavioural SPI engine model.
module tb_spi_xfer_seq;

  localparam int MB  = 4;
  localparam int CSS = 4;
  localparam int CSH = 4;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst, req, req_rd;
  logic [6:0]  req_addr;
  logic [2:0]  req_len;
  logic [31:0] wr_data, rd_data;
  logic        done, err, busy, cs_n, spi_start;
  logic [7:0]  spi_data_in, spi_data_out;
  logic        spi_new_data, spi_busy;

  always #5 clk = ~clk;

  spi_xfer_seq #(.MAX_BYTES(MB), .CS_SETUP(CSS), .CS_HOLD(CSH), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_rd_i(req_rd), .req_addr_i(req_addr),
    .req_len_i(req_len), .wr_data_i(wr_data), .rd_data_o(rd_data), .done_o(done),
    .err_o(err), .busy_o(busy), .cs_n_o(cs_n), .spi_start_o(spi_start),
    .spi_data_in_o(spi_data_in), .spi_data_out_i(spi_data_out),
    .spi_new_data_i(spi_new_data), .spi_busy_i(spi_busy)
  );

  // Engine model: latches a byte when start rises, completes after a random
  // latency with a new_data pulse, may stay busy a little longer afterwards.
  logic       eng_act, nd_prev, eng_stall;
  int         eng_cnt, tail, byte_no;
  int         viol = 0, aborts = 0;
  logic [7:0] eng_resp;
  logic [7:0] resp_tab [0:8];
  logic [7:0] wire_q [$];

  assign spi_busy = eng_act || (tail != 0);

  always @(posedge clk) begin
    if (rst) begin
      eng_act <= 1'b0; spi_new_data <= 1'b0; tail <= 0; nd_prev <= 1'b0;
      byte_no <= 0; spi_data_out <= 8'h00; eng_cnt <= 0; eng_resp <= 8'h00;
    end else begin
      nd_prev      <= spi_new_data;
      spi_new_data <= 1'b0;
      if (nd_prev && spi_start) viol <= viol + 1;
      if (tail != 0) tail <= tail - 1;
      if (eng_act) begin
        if (!spi_start) begin
          eng_act <= 1'b0;
          aborts  <= aborts + 1;
        end else if (eng_cnt != 0) begin
          eng_cnt <= eng_cnt - 1;
        end else if (!eng_stall) begin
          spi_new_data <= 1'b1;
          spi_data_out <= eng_resp;
          eng_act      <= 1'b0;
          tail         <= int'($urandom_range(2, 0));
        end
      end else if (spi_start && !spi_new_data && !nd_prev) begin
        eng_act  <= 1'b1;
        eng_cnt  <= int'($urandom_range(4, 1));
        wire_q.push_back(spi_data_in);
        eng_resp <= resp_tab[byte_no];
        byte_no  <= byte_no + 1;
      end
      if (cs_n) byte_no <= 0;
    end
  end

  int n_asrt = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_resp();
    for (int i = 0; i < 9; i++) resp_tab[i] = 8'($urandom);
  endtask

  task automatic run_txn(input logic rd, input logic [6:0] addr, input logic [2:0] len,
                         input logic [31:0] wd, input logic stall, input logic hold);
    int el, base, cs_fall, st_rise, st_drop, cs_rise, done_n, busy_gap, ab0, v0, dn;
    logic err_v, busy_v, csn_v;
    logic [7:0]  exp_w [$];
    logic [31:0] exp_rd;
    el = (len == 0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
    exp_w = {};
    exp_w.push_back({rd, addr});
    exp_rd = '0;
    if (!stall)
      for (int i = 0; i < el; i++) begin
        exp_w.push_back(rd ? 8'h00 : wd[8*i +: 8]);
        if (rd) exp_rd[8*i +: 8] = resp_tab[i+1];
      end
    eng_stall = stall;
    base = wire_q.size(); ab0 = aborts; v0 = viol;
    cs_fall = -1; st_rise = -1; st_drop = -1; cs_rise = -1; done_n = -1; busy_gap = 0;
    err_v = 1'b0; busy_v = 1'b0; csn_v = 1'b0;
    @(negedge clk);
    req = 1'b1; req_rd = rd; req_addr = addr; req_len = len; wr_data = wd;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (!cs_n && cs_fall < 0) cs_fall = n;
      if (spi_start && st_rise < 0) st_rise = n;
      if (!spi_start && st_rise >= 0 && st_drop < 0) st_drop = n;
      if (cs_n && cs_fall >= 0 && cs_rise < 0) cs_rise = n;
      if (!busy) busy_gap = 1;
      if (done) begin
        done_n = n; err_v = err; busy_v = busy; csn_v = cs_n;
        break;
      end
    end
    chk("done_seen", 64'(done_n >= 0), 1);
    chk("busy_through_txn", 64'(busy_gap), 0);
    chk("busy_at_done", busy_v, 1);
    chk("cs_n_high_at_done", csn_v, 1);
    chk("err", err_v, stall);
    chk("cs_fall_at_accept", 64'(cs_fall), 0);
    chk("wire_count", 64'(wire_q.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      if (base + i < wire_q.size()) chk($sformatf("wire_byte%0d", i), wire_q[base+i], exp_w[i]);
    if (stall) begin
      chk("start_high_cycles", 64'(st_drop - st_rise), TO);
      chk("cs_hold_after_abort", 64'(cs_rise - st_drop), CSH);
      chk("engine_aborts", 64'(aborts - ab0), 1);
    end else begin
      chk("cs_setup", 64'((st_rise - cs_fall) >= CSS), 1);
      chk("start_after_new_data", 64'(viol - v0), 0);
      chk("start_dropped_mid_byte", 64'(aborts - ab0), 0);
    end
    chk("rd_data", rd_data, exp_rd);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("rd_data_held", rd_data, exp_rd);
    chk("busy_idle_after_fin", busy, 0);
    if (hold) begin
      @(negedge clk);
      chk("reaccept_busy", busy, 1);
      chk("reaccept_cs_n", cs_n, 0);
      req = 1'b0;
      dn = 0;
      for (int n = 0; n < 800 && dn == 0; n++) begin
        @(negedge clk);
        if (done) dn = 1;
      end
      chk("reaccept_done", 64'(dn), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dcnt, ok;
    rst = 1'b1; req = 1'b0; req_rd = 1'b0; req_addr = '0; req_len = '0; wr_data = '0;
    eng_stall = 1'b0;
    rand_resp();
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_start", spi_start, 0);
    chk("rst_data_in", spi_data_in, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    run_txn(1'b0, 7'h2A, 3'd2, 32'h0000BEEF, 1'b0, 1'b0);

    resp_tab[0] = 8'h5C; resp_tab[1] = 8'h11; resp_tab[2] = 8'h22;
    resp_tab[3] = 8'h33; resp_tab[4] = 8'h44;
    run_txn(1'b1, 7'h3B, 3'd4, 32'h0, 1'b0, 1'b0);
    chk("read_fixed_rd_data", rd_data, 32'h44332211);

    run_txn(1'b0, 7'h15, 3'd3, 32'h00C0FFEE, 1'b1, 1'b0);

    // Reset during payload byte 2 of a 4-byte read.
    rand_resp();
    eng_stall = 1'b0;
    base = wire_q.size();
    @(negedge clk);
    req = 1'b1; req_rd = 1'b1; req_addr = 7'h44; req_len = 3'd4;
    @(negedge clk);
    req = 1'b0;
    ok = 0;
    for (int n = 0; n < 400 && ok == 0; n++) begin
      if (wire_q.size() - base >= 3) ok = 1;
      else @(negedge clk);
    end
    chk("reach_byte2", 64'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_start", spi_start, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 0);

    rand_resp();
    run_txn(1'b1, 7'h01, 3'd3, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 7'h7F, 3'd0, 32'hA5A5A55A, 1'b0, 1'b0);
    rand_resp();
    run_txn(1'b1, 7'h22, 3'd7, 32'h0, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rand_resp();
      run_txn(1'($urandom_range(1, 0)), 7'($urandom), 3'($urandom_range(7, 0)),
              $urandom, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
